// File: rtl/quad_encoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B/Z, decodes 4x position,
// direction and illegal transitions, and measures step rate over a fixed gate window.
module quad_encoder #(
  parameter int POS_WIDTH   = 16,
  parameter int FILT_LEN    = 3,
  parameter int SPEED_WIDTH = 16,
  parameter int GATE_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        enc_z,
  input  logic                        pos_clr,
  input  logic                        zero_en,
  input  logic                        err_clr,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir,
  output logic                        step,
  output logic                        err,
  output logic [SPEED_WIDTH-1:0]      speed,
  output logic                        speed_valid
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int GCW = $clog2(GATE_CYCLES);

  logic [2:0]             sync1;
  logic [2:0]             sync2;
  logic [2:0]             filt;
  logic [1:0]             ab_cur;
  logic [1:0]             ab_prev;
  logic                   z_prev;
  logic                   z_rise;
  logic                   fwd;
  logic                   rev;
  logic                   illegal;
  logic                   valid_step;
  logic [POS_WIDTH-1:0]   pos_q;
  logic [GCW-1:0]         gate_cnt;
  logic                   gate_wrap;
  logic [SPEED_WIDTH-1:0] window;
  logic [SPEED_WIDTH-1:0] win_next;

  // Bit order in the pin vectors: [0]=A, [1]=B, [2]=Z.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {enc_z, enc_b, enc_a};
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_filt
    logic           f_q;
    logic [FCW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        f_q <= 1'b0;
        cnt <= '0;
      end else if (sync2[i] == f_q) begin
        cnt <= '0;
      end else if (cnt == FCW'(FILT_LEN - 1)) begin
        f_q <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt[i] = f_q;
  end

  assign ab_cur  = {filt[0], filt[1]};
  assign z_rise  = filt[2] & ~z_prev;
  assign illegal = (ab_prev ^ ab_cur) == 2'b11;

  // Forward Gray sequence on {A,B}: 00 -> 01 -> 11 -> 10 -> 00.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({ab_prev, ab_cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
      default: ;
    endcase
  end

  assign valid_step = fwd | rev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab_prev <= '0;
      z_prev  <= 1'b0;
      pos_q   <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ab_prev <= ab_cur;
      z_prev  <= filt[2];
      step    <= valid_step;
      if (valid_step) begin
        dir <= fwd;
      end
      if (pos_clr || (zero_en && z_rise)) begin
        pos_q <= '0;
      end else if (fwd) begin
        pos_q <= pos_q + 1'b1;
      end else if (rev) begin
        pos_q <= pos_q - 1'b1;
      end
      if (illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign position = pos_q;

  assign gate_wrap = gate_cnt == GCW'(GATE_CYCLES - 1);
  assign win_next  = (valid_step && window != '1) ? window + 1'b1 : window;

  // A step decoded on the wrap cycle still belongs to the closing window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_cnt    <= '0;
      window      <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else if (gate_wrap) begin
      gate_cnt    <= '0;
      window      <= '0;
      speed       <= win_next;
      speed_valid <= 1'b1;
    end else begin
      gate_cnt    <= gate_cnt + 1'b1;
      window      <= win_next;
      speed_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_encoder.sv
// Scoreboard bench for quad_encoder: stimulus pushes expected step/speed events,
// a negedge monitor pops and compares them whenever the DUT pulses step or speed_valid.
module tb_quad_encoder;

  typedef struct {
    logic [15:0] pos;
    logic        dir;
    int          cyc;
  } step_t;

  typedef struct {
    logic [15:0] spd;
    logic [2:0]  sat;
    int          cyc;
  } spd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        enc_z = 1'b0;
  logic        pos_clr = 1'b0;
  logic        zero_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] position;
  logic        dir;
  logic        step;
  logic        err;
  logic [15:0] speed;
  logic        speed_valid;
  logic [15:0] sat_position;
  logic        sat_dir;
  logic        sat_step;
  logic        sat_err;
  logic [2:0]  sat_speed;
  logic        sat_speed_valid;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] mpos = '0;
  bit          spd_mon_en = 1'b0;
  step_t       step_q[$];
  spd_t        spd_q[$];
  logic [1:0]  fwd_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quad_encoder #(
    .POS_WIDTH(16), .FILT_LEN(3), .SPEED_WIDTH(16), .GATE_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .pos_clr(pos_clr), .zero_en(zero_en), .err_clr(err_clr),
    .position(position), .dir(dir), .step(step), .err(err),
    .speed(speed), .speed_valid(speed_valid)
  );

  quad_encoder #(
    .POS_WIDTH(16), .FILT_LEN(3), .SPEED_WIDTH(3), .GATE_CYCLES(100)
  ) dut_sat (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .pos_clr(pos_clr), .zero_en(zero_en), .err_clr(err_clr),
    .position(sat_position), .dir(sat_dir), .step(sat_step), .err(sat_err),
    .speed(sat_speed), .speed_valid(sat_speed_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = no step expected, 1 = forward, 2 = reverse; step lands 6 edges after the drive edge.
  task automatic apply_stimulus(input logic [1:0] ab, input int kind, input int hold);
    step_t e;
    @(posedge clk);
    #1;
    {enc_a, enc_b} = ab;
    if (kind == 1) begin
      mpos = mpos + 16'd1;
      e = '{pos: mpos, dir: 1'b1, cyc: cyc + 6};
      step_q.push_back(e);
    end else if (kind == 2) begin
      mpos = mpos - 16'd1;
      e = '{pos: mpos, dir: 1'b0, cyc: cyc + 6};
      step_q.push_back(e);
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic pulse(input int which);
    @(posedge clk);
    #1;
    if (which == 0) pos_clr = 1'b1; else err_clr = 1'b1;
    @(posedge clk);
    #1;
    pos_clr = 1'b0;
    err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    step_t se;
    spd_t  pe;
    if (rst && step) begin
      if (step_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL step_unexpected: step at cycle %0d position 0x%0h, required no step", cyc, position);
      end else begin
        se = step_q.pop_front();
        check_output("step_pos", position, se.pos);
        check_output("step_dir", dir, se.dir);
        check_output("step_cycle", cyc, se.cyc);
      end
    end
    if (rst && speed_valid && spd_mon_en) begin
      if (spd_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL speed_unexpected: speed_valid at cycle %0d speed %0d, required none", cyc, speed);
      end else begin
        pe = spd_q.pop_front();
        check_output("speed_value", speed, pe.spd);
        check_output("speed_sat", sat_speed, pe.sat);
        check_output("speed_sat_valid", sat_speed_valid, 1);
        check_output("speed_cycle", cyc, pe.cyc);
      end
    end
  end

  initial begin
    step_t e;
    spd_t  s;
    int    rel;
    int    k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_position", position, 0);
    check_output("rst_dir", dir, 0);
    check_output("rst_step", step, 0);
    check_output("rst_err", err, 0);
    check_output("rst_speed", speed, 0);
    check_output("rst_speed_valid", speed_valid, 0);
    check_output("rst_sat_outputs", {sat_position, sat_dir, sat_step, sat_err, sat_speed, sat_speed_valid}, 0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) apply_stimulus(fwd_seq[i], 1, 10);
    @(negedge clk);
    check_output("fwd_position", position, 16'd4);
    check_output("fwd_dir", dir, 1);

    pulse(0);
    mpos = '0;
    @(negedge clk);
    check_output("clr_position", position, 0);
    apply_stimulus(2'b10, 2, 10);
    @(negedge clk);
    check_output("rev_wrap_position", position, 16'hFFFF);
    check_output("rev_dir", dir, 0);

    // Forward step 10->00 decoded on the same edge as pos_clr.
    @(posedge clk);
    #1;
    {enc_a, enc_b} = 2'b00;
    e = '{pos: 16'd0, dir: 1'b1, cyc: cyc + 6};
    step_q.push_back(e);
    mpos = '0;
    repeat (5) @(posedge clk);
    #1 pos_clr = 1'b1;
    @(posedge clk);
    #1 pos_clr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("clr_step_position", position, 0);
    check_output("clr_step_dir", dir, 1);

    apply_stimulus(2'b01, 1, 10);
    @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 enc_a = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_output("glitch2_position", position, 16'd1);

    @(posedge clk);
    #1 enc_a = 1'b1;
    e = '{pos: 16'd2, dir: 1'b1, cyc: cyc + 6};
    step_q.push_back(e);
    e = '{pos: 16'd1, dir: 1'b0, cyc: cyc + 9};
    step_q.push_back(e);
    repeat (3) @(posedge clk);
    #1 enc_a = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_output("glitch3_position", position, 16'd1);
    check_output("glitch3_dir", dir, 0);

    apply_stimulus(2'b00, 2, 10);
    apply_stimulus(2'b11, 0, 10);
    @(negedge clk);
    check_output("illegal_err", err, 1);
    check_output("illegal_position", position, 0);
    apply_stimulus(2'b00, 0, 10);
    pulse(1);
    @(negedge clk);
    check_output("errclr_first", err, 0);

    @(posedge clk);
    #1 {enc_a, enc_b} = 2'b11;
    repeat (5) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("errclr_concurrent", err, 1);
    pulse(1);
    @(negedge clk);
    check_output("errclr_alone", err, 0);
    apply_stimulus(2'b10, 1, 10);
    apply_stimulus(2'b00, 1, 10);

    k = 0;
    while (mpos != 16'd37) begin
      apply_stimulus(fwd_seq[k % 4], 1, 5);
      k++;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_output("pre_z_position", position, 16'd37);
    @(posedge clk);
    #1;
    zero_en = 1'b1;
    enc_z = 1'b1;
    mpos = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_output("z_zero_position", position, 0);
    #1;
    zero_en = 1'b0;
    enc_z = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) apply_stimulus(fwd_seq[(k + i) % 4], 1, 6);
    @(posedge clk);
    #1 enc_z = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_output("z_disabled_position", position, 16'd3);
    check_output("pre_rst_queue", step_q.size(), 0);

    #1;
    enc_z = 1'b0;
    {enc_a, enc_b} = 2'b00;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("mid_rst_position", position, 0);
    check_output("mid_rst_dir", dir, 0);
    check_output("mid_rst_err_step", {err, step}, 0);
    check_output("mid_rst_speed", {speed, speed_valid}, 0);
    repeat (3) @(posedge clk);
    mpos = '0;
    spd_mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    for (int w = 1; w <= 3; w++) begin
      s = '{spd: 16'd10, sat: 3'd7, cyc: rel + 100 * w};
      spd_q.push_back(s);
    end
    for (int i = 0; i < 30; i++) apply_stimulus(fwd_seq[i % 4], 1, 10);
    while (cyc < rel + 310) @(posedge clk);
    @(negedge clk);
    spd_mon_en = 1'b0;
    check_output("speed_queue_drained", spd_q.size(), 0);
    check_output("step_queue_drained", step_q.size(), 0);
    check_output("final_position", position, 16'd30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
